// File: rtl/rr_arbiter_n_pkg.sv
// rr_arbiter_n_pkg: shared state encoding, sizing helper and default parameters
package rr_arbiter_n_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam int RR_N_DEF = 4;
   localparam int RR_MAX_HOLD_DEF = 8;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/rr_arbiter_n_pick.sv
// rr_pick: round-robin winner search from ptr as a double-width masked priority encoder
module rr_pick
   import rr_arbiter_n_pkg::*;
#(
   parameter int N = RR_N_DEF,
   localparam int W = clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic [N-1:0] excl,
   output logic [N-1:0] win,
   output logic [W-1:0] win_idx,
   output logic         any
);
   logic [N-1:0]   r;
   logic [N-1:0]   hi;
   logic [2*N-1:0] dbl;
   // Lower copy keeps only bits at or above ptr, so the lowest set bit is the wrap-around winner.
   always_comb begin
      r = req & ~excl;
      hi = r & ({N{1'b1}} << ptr);
      dbl = {r, hi};
      win_idx = '0;
      for (int i = 2*N-1; i >= 0; i--)
         if (dbl[i]) win_idx = W'(i % N);
      any = |r;
      win = any ? (N'(1) << win_idx) : '0;
   end
endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with grant locking and bounded hold under contention
module rr_arbiter_n
   import rr_arbiter_n_pkg::*;
#(
   parameter int N = RR_N_DEF,
   parameter int MAX_HOLD = RR_MAX_HOLD_DEF,
   localparam int W = clog2(N),
   localparam int HW = clog2(MAX_HOLD + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid
);
   state_t         state, state_nx;
   logic [N-1:0]   grant_nx, excl, win;
   logic [W-1:0]   idx_nx, ptr, ptr_nx, win_idx;
   logic [HW-1:0]  hold_cnt, hold_nx;
   logic           any, owner_req, others, hold_full, force_rot;
   rr_pick #(.N(N)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .excl    (excl),
      .win     (win),
      .win_idx (win_idx),
      .any     (any)
   );
   always_comb begin
      owner_req = (state == BUSY) && req[grant_idx];
      others = |(req & ~grant);
      hold_full = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
      force_rot = owner_req && hold_full && others;
      excl = force_rot ? grant : '0;
      state_nx = state;
      grant_nx = grant;
      idx_nx = grant_idx;
      ptr_nx = ptr;
      hold_nx = hold_cnt;
      if ((!owner_req && any) || force_rot) begin
         state_nx = BUSY;
         grant_nx = win;
         idx_nx = win_idx;
         ptr_nx = (win_idx == W'(N-1)) ? '0 : win_idx + 1'b1;
         hold_nx = HW'(1);
      end else if (!owner_req) begin
         state_nx = IDLE;
         grant_nx = '0;
         idx_nx = '0;
      end else if (MAX_HOLD != 0 && !hold_full) begin
         hold_nx = hold_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         grant_idx <= '0;
         grant_valid <= 1'b0;
         ptr <= '0;
         hold_cnt <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         grant_idx <= idx_nx;
         grant_valid <= |grant_nx;
         ptr <= ptr_nx;
         hold_cnt <= hold_nx;
      end
   end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: vector table, hand sequences and randomized model check of rr_arbiter_n
module tb_rr_arbiter_n;
   localparam int N = 4;
   localparam int MH = 4;
   logic       clk, rst, rst0;
   logic [3:0] req, req0, grant, grant0;
   logic [1:0] grant_idx, grant_idx0;
   logic       grant_valid, grant_valid0;
   int         passed, total;
   int         m_owner, m_cnt, m_ptr;
   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] g;
      logic [1:0] idx;
   } vec_t;
   vec_t vt[$];
   rr_arbiter_n #(.N(N), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
   );
   rr_arbiter_n #(.N(N), .MAX_HOLD(0)) dut0 (
      .clk(clk), .rst(rst0), .req(req0),
      .grant(grant0), .grant_idx(grant_idx0), .grant_valid(grant_valid0)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic int pick(input logic [3:0] r, input int p, input int ex);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (r[i] && i != ex) return i;
      end
      return -1;
   endfunction
   task automatic model_step(input logic [3:0] r, input logic rs);
      int w;
      w = -1;
      if (rs) begin
         m_owner = -1;
         m_cnt = 0;
         m_ptr = 0;
      end else if (m_owner < 0 || !r[m_owner]) begin
         w = pick(r, m_ptr, -1);
         if (w < 0) m_owner = -1;
      end else if (m_cnt >= MH && (r & ~(4'(1) << m_owner)) != 0) begin
         w = pick(r, m_ptr, m_owner);
      end else begin
         m_cnt++;
      end
      if (w >= 0) begin
         m_owner = w;
         m_cnt = 1;
         m_ptr = (w + 1) % N;
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model_step(req, rst);
      #1;
   endtask
   task automatic check(input string nm, input logic [3:0] ag, input logic [1:0] ai, input logic av,
                        input logic [3:0] eg, input logic [1:0] ei);
      total++;
      if (ag !== eg || ai !== ei || av !== (eg != 0))
         $display("FAIL %s: got grant=%b idx=%0d valid=%b, want grant=%b idx=%0d valid=%b",
                  nm, ag, ai, av, eg, ei, eg != 0);
      else
         passed++;
   endtask
   task automatic add(input logic rs, input logic [3:0] r, input logic [3:0] g, input logic [1:0] i);
      vt.push_back('{rst: rs, req: r, g: g, idx: i});
   endtask
   initial begin
      logic [3:0] exp_g;
      passed = 0;
      total = 0;
      rst = 1'b1;
      rst0 = 1'b1;
      req = '0;
      req0 = '0;
      m_owner = -1;
      m_cnt = 0;
      m_ptr = 0;
      add(1, 4'b1111, 4'b0000, 0);
      add(1, 4'b1111, 4'b0000, 0);
      for (int k = 0; k < 20; k++)
         add(0, 4'b1111, 4'(1) << ((k / 4) % 4), 2'((k / 4) % 4));
      add(1, 4'b0000, 4'b0000, 0);
      add(0, 4'b0011, 4'b0001, 0);
      add(0, 4'b0011, 4'b0001, 0);
      add(0, 4'b0010, 4'b0010, 1);
      add(0, 4'b0011, 4'b0010, 1);
      add(0, 4'b0011, 4'b0010, 1);
      add(0, 4'b0011, 4'b0010, 1);
      add(0, 4'b0011, 4'b0001, 0);
      add(0, 4'b1000, 4'b1000, 3);
      add(0, 4'b1001, 4'b1000, 3);
      add(0, 4'b0001, 4'b0001, 0);
      add(0, 4'b1000, 4'b1000, 3);
      add(0, 4'b0000, 4'b0000, 0);
      foreach (vt[k]) begin
         rst = vt[k].rst;
         req = vt[k].req;
         tick();
         check($sformatf("vec%0d", k), grant, grant_idx, grant_valid, vt[k].g, vt[k].idx);
      end
      rst = 1'b1;
      req = '0;
      tick();
      check("solo_rst", grant, grant_idx, grant_valid, 4'b0000, 0);
      rst = 1'b0;
      req = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("solo%0d", k), grant, grant_idx, grant_valid, 4'b0100, 2);
      end
      req = 4'b0000;
      tick();
      check("solo_release", grant, grant_idx, grant_valid, 4'b0000, 0);
      rst0 = 1'b1;
      tick();
      check("h0_rst", grant0, grant_idx0, grant_valid0, 4'b0000, 0);
      rst0 = 1'b0;
      req0 = 4'b0110;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("h0_hold%0d", k), grant0, grant_idx0, grant_valid0, 4'b0010, 1);
      end
      rst0 = 1'b1;
      tick();
      check("h0_midrst", grant0, grant_idx0, grant_valid0, 4'b0000, 0);
      rst0 = 1'b0;
      req0 = 4'b1111;
      tick();
      check("h0_after", grant0, grant_idx0, grant_valid0, 4'b0001, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) < 30) req = 4'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         tick();
         exp_g = (m_owner < 0) ? 4'b0000 : 4'(1) << m_owner;
         check($sformatf("rand%0d", k), grant, grant_idx, grant_valid, exp_g,
               (m_owner < 0) ? 2'd0 : 2'(m_owner));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
